// File: rtl/vid_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vid_timing_gen_if
// Purpose : bundles the run control, raster configuration, FIFO status and all
//           timing outputs of vid_timing_gen into one interface.
// Params  : CW   - width of every horizontal/vertical position and count field
//           DIVW - width of the pixel divider field
// Modports: master - drives en/cfg_*/fifo_empty, observes timing outputs
//           slave  - the timing generator itself
// Config  : VID_TG_IRQ_EN adds irq_clr (master->slave) and irq (slave->master).
// -----------------------------------------------------------------------------
interface vid_timing_gen_if #(
    parameter int CW   = 13,
    parameter int DIVW = 6
);
    // run control and configuration
    logic            en;
    logic            cfg_load;
    logic [DIVW-1:0] cfg_pcnt;
    logic [CW-1:0]   cfg_hsize;
    logic [CW-1:0]   cfg_hend;
    logic [CW-1:0]   cfg_hs_start;
    logic [CW-1:0]   cfg_hs_end;
    logic [CW-1:0]   cfg_vsize;
    logic [CW-1:0]   cfg_vend;
    logic [CW-1:0]   cfg_vs_start;
    logic [CW-1:0]   cfg_vs_end;
    logic            fifo_empty;

    // timing outputs
    logic            pix_stb;
    logic [CW-1:0]   hcnt;
    logic [CW-1:0]   vcnt;
    logic            hsync;
    logic            hblank;
    logic            vsync;
    logic            vblank;
    logic            de;
    logic            pix_req;
    logic            line_start;
    logic            frame_start;
    logic            underrun;

`ifdef VID_TG_IRQ_EN
    logic            irq_clr;
    logic            irq;

    modport master (
        output en, cfg_load, cfg_pcnt, cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end,
               cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end, fifo_empty, irq_clr,
        input  pix_stb, hcnt, vcnt, hsync, hblank, vsync, vblank, de, pix_req,
               line_start, frame_start, underrun, irq
    );

    modport slave (
        input  en, cfg_load, cfg_pcnt, cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end,
               cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end, fifo_empty, irq_clr,
        output pix_stb, hcnt, vcnt, hsync, hblank, vsync, vblank, de, pix_req,
               line_start, frame_start, underrun, irq
    );
`else
    modport master (
        output en, cfg_load, cfg_pcnt, cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end,
               cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end, fifo_empty,
        input  pix_stb, hcnt, vcnt, hsync, hblank, vsync, vblank, de, pix_req,
               line_start, frame_start, underrun
    );

    modport slave (
        input  en, cfg_load, cfg_pcnt, cfg_hsize, cfg_hend, cfg_hs_start, cfg_hs_end,
               cfg_vsize, cfg_vend, cfg_vs_start, cfg_vs_end, fifo_empty,
        output pix_stb, hcnt, vcnt, hsync, hblank, vsync, vblank, de, pix_req,
               line_start, frame_start, underrun
    );
`endif
endinterface

// File: rtl/vid_timing_gen.sv
// -----------------------------------------------------------------------------
// vid_timing_gen
// Purpose : raster timing generator for the pixel pipeline. Divides clk into a
//           pixel strobe, runs horizontal/vertical counters and decodes
//           hsync/hblank/vsync/vblank/de plus a per-pixel FIFO read request.
//           Configuration is shadowed and only switches at a frame boundary,
//           so reprogramming never tears a frame.
// Ports   : clk     - clock
//           reset_n - asynchronous active-low reset
//           bus     - vid_timing_gen_if.slave (en, cfg_*, fifo_empty in;
//                     pix_stb, hcnt, vcnt, sync/blank/de, pix_req,
//                     line_start, frame_start, underrun out)
// Config  : VID_TG_IRQ_EN defined -> vblank-rise interrupt (bus.irq, cleared
//           by bus.irq_clr; set wins over clear; survives en=0).
//           Undefined -> no interrupt logic.
// All outputs are registered; every decoded output is computed from the next
// counter values so it lines up with hcnt/vcnt in the same cycle.
// -----------------------------------------------------------------------------
module vid_timing_gen #(
    parameter int CW   = 13,
    parameter int DIVW = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    vid_timing_gen_if.slave bus
);

    localparam logic [CW-1:0]   C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DIVW-1:0] D_ZERO = {DIVW{1'b0}};
    localparam logic [DIVW-1:0] D_ONE  = {{(DIVW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;

    // shadow configuration used by the running frame
    logic [DIVW-1:0] r_sh_pcnt;
    logic [CW-1:0]   r_sh_hsize;
    logic [CW-1:0]   r_sh_hend;
    logic [CW-1:0]   r_sh_hs_start;
    logic [CW-1:0]   r_sh_hs_end;
    logic [CW-1:0]   r_sh_vsize;
    logic [CW-1:0]   r_sh_vend;
    logic [CW-1:0]   r_sh_vs_start;
    logic [CW-1:0]   r_sh_vs_end;
    logic            r_cfg_pend;

    // counters and registered outputs
    logic [DIVW-1:0] r_div;
    logic [CW-1:0]   r_hcnt;
    logic [CW-1:0]   r_vcnt;
    logic            r_pix_stb;
    logic            r_hsync;
    logic            r_hblank;
    logic            r_vsync;
    logic            r_vblank;
    logic            r_de;
    logic            r_pix_req;
    logic            r_line_start;
    logic            r_frame_start;
    logic            r_underrun;

    // next-cycle values
    logic            w_start;
    logic            w_run_nx;
    logic            w_step;
    logic            w_hwrap;
    logic            w_vwrap;
    logic            w_fwrap;
    logic            w_load;
    logic [DIVW-1:0] w_e_pcnt;
    logic [CW-1:0]   w_e_hsize;
    logic [CW-1:0]   w_e_hs_start;
    logic [CW-1:0]   w_e_hs_end;
    logic [CW-1:0]   w_e_vsize;
    logic [CW-1:0]   w_e_vs_start;
    logic [CW-1:0]   w_e_vs_end;
    logic [DIVW-1:0] w_div_nx;
    logic [CW-1:0]   w_h_nx;
    logic [CW-1:0]   w_v_nx;
    logic            w_pix_stb_nx;
    logic            w_hsync_nx;
    logic            w_hblank_nx;
    logic            w_vsync_nx;
    logic            w_vblank_nx;
    logic            w_de_nx;
    logic            w_pix_req_nx;
    logic            w_line_start_nx;
    logic            w_frame_start_nx;
    logic            w_underrun_nx;
    logic            w_cfg_pend_nx;

    // FSM next state: w_start marks the IDLE->RUN edge, w_run_nx the next state
    always_comb begin
        w_start  = 1'b0;
        w_run_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_start  = bus.en;
                w_run_nx = bus.en;
            end
            ST_RUN: begin
                w_start  = 1'b0;
                w_run_nx = bus.en;
            end
            default: begin
                w_start  = 1'b0;
                w_run_nx = 1'b0;
            end
        endcase
    end

    // Counter stepping, frame wrap and the configuration the next cycle will use
    always_comb begin
        w_step  = (r_state == ST_RUN) && r_pix_stb;
        w_hwrap = (r_hcnt == r_sh_hend);
        w_vwrap = (r_vcnt == r_sh_vend);
        w_fwrap = w_step && w_hwrap && w_vwrap;
        // shadows switch on the edge that produces frame_start (or on start-up)
        w_load  = w_start || (w_run_nx && w_fwrap && r_cfg_pend);

        if (w_load) begin
            w_e_pcnt     = bus.cfg_pcnt;
            w_e_hsize    = bus.cfg_hsize;
            w_e_hs_start = bus.cfg_hs_start;
            w_e_hs_end   = bus.cfg_hs_end;
            w_e_vsize    = bus.cfg_vsize;
            w_e_vs_start = bus.cfg_vs_start;
            w_e_vs_end   = bus.cfg_vs_end;
        end else begin
            w_e_pcnt     = r_sh_pcnt;
            w_e_hsize    = r_sh_hsize;
            w_e_hs_start = r_sh_hs_start;
            w_e_hs_end   = r_sh_hs_end;
            w_e_vsize    = r_sh_vsize;
            w_e_vs_start = r_sh_vs_start;
            w_e_vs_end   = r_sh_vs_end;
        end

        if (!w_run_nx || w_start) begin
            w_h_nx   = C_ZERO;
            w_v_nx   = C_ZERO;
            w_div_nx = D_ZERO;
        end else begin
            if (w_step) begin
                if (w_hwrap) begin
                    w_h_nx = C_ZERO;
                    if (w_vwrap) begin
                        w_v_nx = C_ZERO;
                    end else begin
                        w_v_nx = r_vcnt + C_ONE;
                    end
                end else begin
                    // plain +1 wraps at 2^CW-1 when hend is unreachable
                    w_h_nx = r_hcnt + C_ONE;
                    w_v_nx = r_vcnt;
                end
            end else begin
                w_h_nx = r_hcnt;
                w_v_nx = r_vcnt;
            end
            // the divider always hits pcnt exactly on a step, so a frame wrap
            // returns it to 0 before a new pcnt takes effect
            if (r_div == r_sh_pcnt) begin
                w_div_nx = D_ZERO;
            end else begin
                w_div_nx = r_div + D_ONE;
            end
        end
    end

    // Output decode from the next counter values (idle values when not running)
    always_comb begin
        if (w_run_nx) begin
            w_pix_stb_nx     = (w_div_nx == w_e_pcnt);
            w_hsync_nx       = (w_h_nx >= w_e_hs_start) && (w_h_nx < w_e_hs_end);
            w_hblank_nx      = (w_h_nx >= w_e_hsize);
            w_vsync_nx       = (w_v_nx >= w_e_vs_start) && (w_v_nx < w_e_vs_end);
            w_vblank_nx      = (w_v_nx >= w_e_vsize);
            w_line_start_nx  = w_start || (w_step && w_hwrap);
            w_frame_start_nx = w_start || w_fwrap;
        end else begin
            w_pix_stb_nx     = 1'b0;
            w_hsync_nx       = 1'b0;
            w_hblank_nx      = 1'b1;
            w_vsync_nx       = 1'b0;
            w_vblank_nx      = 1'b1;
            w_line_start_nx  = 1'b0;
            w_frame_start_nx = 1'b0;
        end
        w_de_nx      = ~w_hblank_nx & ~w_vblank_nx;
        w_pix_req_nx = w_de_nx & w_pix_stb_nx;

        if (w_run_nx && !w_start) begin
            w_underrun_nx = r_underrun | (r_pix_req & bus.fifo_empty);
            // a load request arriving on the switch edge waits for the next frame
            w_cfg_pend_nx = bus.cfg_load | (r_cfg_pend & ~w_load);
        end else begin
            w_underrun_nx = 1'b0;
            w_cfg_pend_nx = 1'b0;
        end
    end

    // FSM state, shadows, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_sh_pcnt     <= D_ZERO;
            r_sh_hsize    <= C_ZERO;
            r_sh_hend     <= C_ZERO;
            r_sh_hs_start <= C_ZERO;
            r_sh_hs_end   <= C_ZERO;
            r_sh_vsize    <= C_ZERO;
            r_sh_vend     <= C_ZERO;
            r_sh_vs_start <= C_ZERO;
            r_sh_vs_end   <= C_ZERO;
            r_cfg_pend    <= 1'b0;
            r_div         <= D_ZERO;
            r_hcnt        <= C_ZERO;
            r_vcnt        <= C_ZERO;
            r_pix_stb     <= 1'b0;
            r_hsync       <= 1'b0;
            r_hblank      <= 1'b1;
            r_vsync       <= 1'b0;
            r_vblank      <= 1'b1;
            r_de          <= 1'b0;
            r_pix_req     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_run_nx) begin
                r_state <= ST_RUN;
            end else begin
                r_state <= ST_IDLE;
            end
            if (w_load) begin
                r_sh_pcnt     <= bus.cfg_pcnt;
                r_sh_hsize    <= bus.cfg_hsize;
                r_sh_hend     <= bus.cfg_hend;
                r_sh_hs_start <= bus.cfg_hs_start;
                r_sh_hs_end   <= bus.cfg_hs_end;
                r_sh_vsize    <= bus.cfg_vsize;
                r_sh_vend     <= bus.cfg_vend;
                r_sh_vs_start <= bus.cfg_vs_start;
                r_sh_vs_end   <= bus.cfg_vs_end;
            end else begin
                r_sh_pcnt     <= r_sh_pcnt;
                r_sh_hsize    <= r_sh_hsize;
                r_sh_hend     <= r_sh_hend;
                r_sh_hs_start <= r_sh_hs_start;
                r_sh_hs_end   <= r_sh_hs_end;
                r_sh_vsize    <= r_sh_vsize;
                r_sh_vend     <= r_sh_vend;
                r_sh_vs_start <= r_sh_vs_start;
                r_sh_vs_end   <= r_sh_vs_end;
            end
            r_cfg_pend    <= w_cfg_pend_nx;
            r_div         <= w_div_nx;
            r_hcnt        <= w_h_nx;
            r_vcnt        <= w_v_nx;
            r_pix_stb     <= w_pix_stb_nx;
            r_hsync       <= w_hsync_nx;
            r_hblank      <= w_hblank_nx;
            r_vsync       <= w_vsync_nx;
            r_vblank      <= w_vblank_nx;
            r_de          <= w_de_nx;
            r_pix_req     <= w_pix_req_nx;
            r_line_start  <= w_line_start_nx;
            r_frame_start <= w_frame_start_nx;
            r_underrun    <= w_underrun_nx;
        end
    end

    assign bus.pix_stb     = r_pix_stb;
    assign bus.hcnt        = r_hcnt;
    assign bus.vcnt        = r_vcnt;
    assign bus.hsync       = r_hsync;
    assign bus.hblank      = r_hblank;
    assign bus.vsync       = r_vsync;
    assign bus.vblank      = r_vblank;
    assign bus.de          = r_de;
    assign bus.pix_req     = r_pix_req;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.underrun    = r_underrun;

`ifdef VID_TG_IRQ_EN
    logic r_irq;
    logic w_irq_set;
    logic w_irq_nx;

    // vblank rises when a pixel step carries vcnt onto vsize; set beats clear
    always_comb begin
        w_irq_set = w_run_nx && !w_start && w_step && w_hwrap && (w_v_nx == w_e_vsize);
        if (w_irq_set) begin
            w_irq_nx = 1'b1;
        end else if (bus.irq_clr) begin
            w_irq_nx = 1'b0;
        end else begin
            w_irq_nx = r_irq;
        end
    end

    // Interrupt flag, independent of en so it survives a stop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_nx;
        end
    end

    assign bus.irq = r_irq;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Scoreboard bench for vid_timing_gen: stimulus pushes expected pixel records
// and line/frame periods into queues; a negedge monitor pops and compares.
module tb_vid_timing_gen;
    localparam int CW   = 13;
    localparam int DIVW = 6;

    logic clk = 1'b0;
    logic reset_n;

    vid_timing_gen_if #(.CW(CW), .DIVW(DIVW)) bus ();

    vid_timing_gen #(.CW(CW), .DIVW(DIVW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic [5:0]    f;   // hsync, hblank, vsync, vblank, de, pix_req
    } pix_t;

    pix_t pq[$];
    int   fq[$];
    int   lq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fcnt = 0, lcnt = 0;
    bit   f_have = 1'b0, l_have = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // expected pixel sequence of one full frame, straight from the output definitions
    task automatic push_frame(input int hsize, input int hend, input int hss, input int hse,
                              input int vsize, input int vend, input int vss, input int vse);
        pix_t p;
        logic hs, hb, vs, vb, de;
        for (int v = 0; v <= vend; v++) begin
            for (int h = 0; h <= hend; h++) begin
                hs  = (h >= hss) && (h < hse);
                hb  = (h >= hsize);
                vs  = (v >= vss) && (v < vse);
                vb  = (v >= vsize);
                de  = !hb && !vb;
                p.h = h[CW-1:0];
                p.v = v[CW-1:0];
                p.f = {hs, hb, vs, vb, de, de};
                pq.push_back(p);
            end
        end
    endtask

    task automatic set_common();
        bus.cfg_hsize    = 13'd4;
        bus.cfg_hend     = 13'd6;
        bus.cfg_hs_start = 13'd5;
        bus.cfg_hs_end   = 13'd6;
        bus.cfg_vsize    = 13'd2;
        bus.cfg_vend     = 13'd3;
        bus.cfg_vs_start = 13'd2;
        bus.cfg_vs_end   = 13'd3;
    endtask

    task automatic check_idle(input string name);
        logic [35:0] exp_v;
        exp_v = {13'd0, 13'd0, 10'b0010100000};
        chk(name, 64'({bus.hcnt, bus.vcnt, bus.pix_stb, bus.hsync, bus.hblank, bus.vsync,
                       bus.vblank, bus.de, bus.pix_req, bus.line_start, bus.frame_start,
                       bus.underrun}), 64'(exp_v));
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((pq.size() + fq.size() + lq.size()) != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 64'(pq.size() + fq.size() + lq.size()), 64'd0);
        pq.delete();
        fq.delete();
        lq.delete();
    endtask

    task automatic stop_run();
        bus.en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Monitor: pixel records on pix_stb, frame and line periods on their pulses
    always @(negedge clk) begin
        pix_t e;
        if (bus.pix_stb && pq.size() > 0) begin
            e = pq.pop_front();
            chk("pixel", 64'({bus.hcnt, bus.vcnt, bus.hsync, bus.hblank, bus.vsync,
                              bus.vblank, bus.de, bus.pix_req}), 64'(e));
        end
        fcnt++;
        lcnt++;
        if (bus.frame_start) begin
            if (f_have && fq.size() > 0) chk("frame_period", 64'(fcnt), 64'(fq.pop_front()));
            f_have = 1'b1;
            fcnt   = 0;
        end
        if (bus.line_start) begin
            if (l_have && lq.size() > 0) chk("line_period", 64'(lcnt), 64'(lq.pop_front()));
            l_have = 1'b1;
            lcnt   = 0;
        end
        if (!bus.en) begin
            f_have = 1'b0;
            l_have = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        reset_n        = 1'b0;
        bus.en         = 1'b1;
        bus.cfg_load   = 1'b0;
        bus.cfg_pcnt   = 6'd0;
        bus.fifo_empty = 1'b0;
`ifdef VID_TG_IRQ_EN
        bus.irq_clr    = 1'b0;
`endif
        set_common();

        // 1: reset with en=1, then release with en=0
        #22;
        check_idle("reset_state");
        bus.en = 1'b0;
        #3 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle_after_release");

        // 2: pcnt=0, line 7 clk, frame 28 clk
        push_frame(4, 6, 5, 6, 2, 3, 2, 3);
        fq.push_back(28);
        repeat (4) lq.push_back(7);
        bus.en = 1'b1;
        wait_drain(200);
        stop_run();

        // 3: pcnt=2, line 21 clk, frame 84 clk
        bus.cfg_pcnt = 6'd2;
        push_frame(4, 6, 5, 6, 2, 3, 2, 3);
        fq.push_back(84);
        repeat (4) lq.push_back(21);
        bus.en = 1'b1;
        wait_drain(400);
        stop_run();

        // 4: mid-frame cfg_load with hend=9 takes effect at the next frame
        bus.cfg_pcnt = 6'd0;
        push_frame(4, 6, 5, 6, 2, 3, 2, 3);
        push_frame(4, 9, 5, 6, 2, 3, 2, 3);
        fq.push_back(28);
        fq.push_back(40);
        repeat (4) lq.push_back(7);
        repeat (4) lq.push_back(10);
        bus.en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.cfg_hend = 13'd9;
        bus.cfg_load = 1'b1;
        @(posedge clk); #1;
        bus.cfg_load = 1'b0;
        wait_drain(400);
        stop_run();
        bus.cfg_hend = 13'd6;

        // 7: degenerate sync window and vsize=0 with pcnt=1
        bus.cfg_pcnt     = 6'd1;
        bus.cfg_hs_start = 13'd6;
        bus.cfg_hs_end   = 13'd5;
        bus.cfg_vsize    = 13'd0;
        push_frame(4, 6, 6, 5, 0, 3, 2, 3);
        fq.push_back(56);
        bus.en = 1'b1;
        wait_drain(300);
        stop_run();
        set_common();
        bus.cfg_pcnt = 6'd0;

        // 5: underrun from the first pix_req, sticky until en=0
        bus.fifo_empty = 1'b1;
        bus.en = 1'b1;
        @(posedge clk); #1;
        chk("first_pix_req", 64'(bus.pix_req), 64'd1);
        chk("underrun_before", 64'(bus.underrun), 64'd0);
        @(posedge clk); #1;
        chk("underrun_set", 64'(bus.underrun), 64'd1);
        bus.fifo_empty = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("underrun_hold", 64'(bus.underrun), 64'd1);
        bus.en = 1'b0;
        @(posedge clk); #1;
        chk("underrun_clear", 64'(bus.underrun), 64'd0);
        @(posedge clk); #1;

        // 6: en=0 at hcnt=3
        bus.en = 1'b1;
        k = 0;
        while (!(bus.hcnt == 13'd3 && bus.de) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_hcnt3", 64'(bus.hcnt), 64'd3);
        bus.en = 1'b0;
        @(posedge clk); #1;
        chk("stop_hcnt", 64'(bus.hcnt), 64'd0);
        chk("stop_vcnt", 64'(bus.vcnt), 64'd0);
        chk("stop_hblank", 64'(bus.hblank), 64'd1);
        chk("stop_pix_stb", 64'(bus.pix_stb), 64'd0);
        @(posedge clk); #1;

`ifdef VID_TG_IRQ_EN
        // irq: set on vblank rise, coincident clear loses, next clear wins
        bus.irq_clr = 1'b1;
        @(posedge clk); #1;
        bus.irq_clr = 1'b0;
        chk("irq_cleared", 64'(bus.irq), 64'd0);
        bus.en = 1'b1;
        k = 0;
        while (!(bus.hcnt == 13'd6 && bus.vcnt == 13'd1) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("irq_before_rise", 64'(bus.irq), 64'd0);
        bus.irq_clr = 1'b1;
        @(posedge clk); #1;
        chk("vblank_rise", 64'(bus.vblank), 64'd1);
        chk("irq_set_wins", 64'(bus.irq), 64'd1);
        @(posedge clk); #1;
        chk("irq_clr", 64'(bus.irq), 64'd0);
        bus.irq_clr = 1'b0;
        stop_run();
`endif

        // async reset mid-frame: outputs drop at once
        bus.en = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        chk("busy_before_reset", 64'(bus.hcnt), 64'd2);
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
`ifdef VID_TG_IRQ_EN
        chk("irq_reset", 64'(bus.irq), 64'd0);
`endif
        bus.en = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after_async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
